data_mem_unit: RTL and testbench

Parametrised, multi-cycle data memory for the pipelined MIPS datapath, sitting in the MEM stage in place of the single-cycle data memory. It supports configurable latency, byte/half/word access with signed or unsigned loads, and little-endian byte lanes. It drives a `Busy` stall to the hazard unit while an access is in flight. Read results are registered and held until the next read completes.

---
 rtl/data_mem_unit.sv | 214 +++++++++++++++++++++
 tb/tb_data_mem_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// data_mem_unit: multi-cycle little-endian byte/half/word data memory for the MEM stage.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module data_mem_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic        Misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // The counter holds the number of WAIT cycles still to go after the current one.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic       LAT_ONE  = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW+1:0]  addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [1:0]     size_q, size_d;
  logic           uns_q, uns_d;
  logic           wr_q, wr_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           done_q, done_d;
  logic           mis_q, mis_d;

  logic [31:0]    mem_q [DEPTH_WORDS];

  logic           req_s;
  logic           commit_s;
  logic [AW+1:0]  acc_addr_s;
  logic [31:0]    acc_wdata_s;
  logic [1:0]     acc_size_s;
  logic           acc_uns_s;
  logic           acc_wr_s;
  logic [AW-1:0]  widx_s;
  logic [1:0]     lane_s;
  logic           fault_s;
  logic [3:0]     be_s;
  logic [31:0]    wlane_s;
  logic           wr_en_s;

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] ln);
    case (sz)
      2'b00:   byte_en = 4'b0001 << ln;
      2'b01:   byte_en = ln[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   store_lanes = {4{wd[7:0]}};
      2'b01:   store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] ln, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   load_ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  assign req_s = MemRead | MemWrite;

  // With LATENCY=1 the commit happens on the accepting edge, so it uses the live inputs.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_addr_s  = Address[AW+1:0];
      acc_wdata_s = WriteData;
      acc_size_s  = Size;
      acc_uns_s   = Unsigned;
      acc_wr_s    = MemWrite;
    end else begin
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
      acc_size_s  = size_q;
      acc_uns_s   = uns_q;
      acc_wr_s    = wr_q;
    end
  end

  assign commit_s = ((state_q == S_IDLE) && req_s && LAT_ONE) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd0));
  assign widx_s   = acc_addr_s[AW+1:2];
  assign lane_s   = acc_addr_s[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault_s = ((acc_size_s == 2'b01) && lane_s[0]) ||
                   (acc_size_s[1] && (lane_s != 2'b00));
`else
  assign fault_s = 1'b0;
`endif

  assign be_s    = byte_en(acc_size_s, lane_s);
  assign wlane_s = store_lanes(acc_size_s, acc_wdata_s);
  assign wr_en_s = commit_s & acc_wr_s & ~fault_s & Reset;

  // Next-state and output logic for the access FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          addr_d  = Address[AW+1:0];
          wdata_d = WriteData;
          size_d  = Size;
          uns_d   = Unsigned;
          wr_d    = MemWrite;
          cnt_d   = CNT_INIT;
          state_d = LAT_ONE ? S_DONE : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (commit_s) begin
      done_d = 1'b1;
      mis_d  = fault_s;
      if (!acc_wr_s && !fault_s) begin
        rdata_d = load_ext(mem_q[widx_s], acc_size_s, lane_s, acc_uns_s);
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // Control and result registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  // Storage array; contents survive reset, only enabled lanes are written.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en_s && be_s[i]) begin
        mem_q[widx_s][8*i +: 8] <= wlane_s[8*i +: 8];
      end
    end
  end

  assign Busy       = Reset & (((state_q == S_IDLE) & req_s) | (state_q == S_WAIT));
  assign ReadData   = rdata_q;
  assign Done       = done_q;
  assign Misaligned = mis_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed scoreboard bench for data_mem_unit (LATENCY=2 main instance, LATENCY=1 throughput instance).
module tb_data_mem_unit;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          total = 0;
  int          bad   = 0;
  exp_t        exp_q [$];
  logic [31:0] b_q [$];

  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_rd, a_wr, a_uns, a_busy, a_done, a_mis;
  logic [1:0]  a_size;

  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_rd, b_wr, b_uns, b_busy, b_done, b_mis;
  logic [1:0]  b_size;

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_a (
    .Clk(clk), .Reset(rst_n), .Address(a_addr), .WriteData(a_wdata),
    .MemRead(a_rd), .MemWrite(a_wr), .Size(a_size), .Unsigned(a_uns),
    .ReadData(a_rdata), .Busy(a_busy), .Done(a_done), .Misaligned(a_mis)
  );

  data_mem_unit #(.DEPTH_WORDS(1024), .LATENCY(1)) dut_b (
    .Clk(clk), .Reset(rst_n), .Address(b_addr), .WriteData(b_wdata),
    .MemRead(b_rd), .MemWrite(b_wr), .Size(b_size), .Unsigned(b_uns),
    .ReadData(b_rdata), .Busy(b_busy), .Done(b_done), .Misaligned(b_mis)
  );

  function automatic void chk(input string tag, input bit ok,
                              input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endfunction

  task automatic access(input string nm, input logic wr, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [1:0] sz, input logic un,
                        input logic [31:0] erd, input logic emis);
    exp_t e;
    int   cyc;
    exp_q.push_back('{rd: erd, mis: emis});
    @(negedge clk);
    a_addr = ad; a_wdata = wd; a_size = sz; a_uns = un; a_wr = wr; a_rd = ~wr;
    #1;
    chk({nm, "_busy_c0"}, a_busy === 1'b1, a_busy, 1'b1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!a_done && cyc < 2) chk({nm, "_busy_wait"}, a_busy === 1'b1, a_busy, 1'b1);
    end while (!a_done && cyc < 10);
    chk({nm, "_done_cycle"}, cyc === 2, cyc, 2);
    chk({nm, "_busy_done"}, a_busy === 1'b0, a_busy, 1'b0);
    e = exp_q.pop_front();
    chk({nm, "_rdata"}, a_rdata === e.rd, a_rdata, e.rd);
    chk({nm, "_misaligned"}, a_mis === e.mis, a_mis, e.mis);
    a_wr = 1'b0; a_rd = 1'b0;
    @(negedge clk);
    chk({nm, "_done_pulse"}, a_done === 1'b0, a_done, 1'b0);
  endtask

  task automatic b_store(input logic [31:0] ad, input logic [31:0] wd);
    @(negedge clk);
    b_addr = ad; b_wdata = wd; b_size = 2'b10; b_wr = 1'b1;
    #1;
    chk("b_store_busy", b_busy === 1'b1, b_busy, 1'b1);
    @(negedge clk);
    chk("b_store_done", b_done === 1'b1, b_done, 1'b1);
    b_wr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dones;
    logic [31:0] prev;
    logic [31:0] bexp;
    logic        eb;
    rst_n = 1'b0;
    a_addr = 32'd0; a_wdata = 32'd0; a_rd = 1'b0; a_wr = 1'b0; a_size = 2'b00; a_uns = 1'b0;
    b_addr = 32'd0; b_wdata = 32'd0; b_rd = 1'b0; b_wr = 1'b0; b_size = 2'b10; b_uns = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rdata", a_rdata === 32'd0, a_rdata, 32'd0);
    chk("reset_busy", a_busy === 1'b0, a_busy, 1'b0);
    chk("reset_done", a_done === 1'b0, a_done, 1'b0);
    chk("reset_mis", a_mis === 1'b0, a_mis, 1'b0);
    rst_n = 1'b1;

    access("st_w10",   1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0);
    access("ld_w10",   1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
    access("st_b11",   1'b1, 32'h11, 32'hAAAAAA80, 2'b00, 1'b0, 32'hDEADBEEF, 1'b0);
    access("ld_bs11",  1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
    access("ld_bu11",  1'b0, 32'h11, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0);
    access("ld_w10b",  1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD80EF, 1'b0);
    access("ld_w12",   1'b0, 32'h12, 32'h0, 2'b10, 1'b0, 32'hDEAD80EF, TRAP);
    prev = TRAP ? 32'hDEAD80EF : 32'hFFFFDEAD;
    access("ld_hs13",  1'b0, 32'h13, 32'h0, 2'b01, 1'b0, prev, TRAP);
    access("st_h11",   1'b1, 32'h11, 32'h99991234, 2'b01, 1'b0, prev, TRAP);
    access("ld_w10c",  1'b0, 32'h10, 32'h0, 2'b10, 1'b0, TRAP ? 32'hDEAD80EF : 32'hDEAD1234, 1'b0);
    access("st_wrap",  1'b1, 32'h1010, 32'h12345678, 2'b10, 1'b0,
           TRAP ? 32'hDEAD80EF : 32'hDEAD1234, 1'b0);
    access("ld_wrap",  1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h12345678, 1'b0);
    access("st_w14",   1'b1, 32'h14, 32'h00000000, 2'b10, 1'b0, 32'h12345678, 1'b0);
    access("st_h16",   1'b1, 32'h16, 32'h1111CAFE, 2'b01, 1'b0, 32'h12345678, 1'b0);
    access("ld_w14",   1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 32'hCAFE0000, 1'b0);
    access("ld_hs16",  1'b0, 32'h16, 32'h0, 2'b01, 1'b0, 32'hFFFFCAFE, 1'b0);
    access("ld_bu17",  1'b0, 32'h17, 32'h0, 2'b00, 1'b1, 32'h000000CA, 1'b0);
    access("ld_s3_14", 1'b0, 32'h14, 32'h0, 2'b11, 1'b0, 32'hCAFE0000, 1'b0);
    access("ld_hu16",  1'b0, 32'h16, 32'h0, 2'b01, 1'b1, 32'h0000CAFE, 1'b0);
    access("st_w20",   1'b1, 32'h20, 32'h55555555, 2'b10, 1'b0, 32'h0000CAFE, 1'b0);
    access("ld_w20",   1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h55555555, 1'b0);

    // LATENCY=1 instance: preload, then three back-to-back loads with the request held.
    b_store(32'h0, 32'h11111111);
    b_store(32'h4, 32'h22222222);
    b_store(32'h8, 32'h33333333);
    @(negedge clk);
    b_addr = 32'h0; b_size = 2'b10; b_rd = 1'b1;
    b_q.push_back(32'h11111111);
    #1;
    chk("b_busy_c0", b_busy === 1'b1, b_busy, 1'b1);
    dones = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      eb = (c % 2 == 1);
      chk("b_done_seq", b_done === eb, b_done, eb);
      eb = (c % 2 == 0);
      chk("b_busy_seq", b_busy === eb, b_busy, eb);
      if (b_done) begin
        dones++;
        if (b_q.size() > 0) begin
          bexp = b_q.pop_front();
          chk("b_rdata", b_rdata === bexp, b_rdata, bexp);
        end
        if (c < 5) begin
          b_addr = b_addr + 32'd4;
          b_q.push_back((c == 1) ? 32'h22222222 : 32'h33333333);
        end else begin
          b_rd = 1'b0;
        end
      end
    end
    chk("b_done_count", dones === 3, dones, 3);
    @(negedge clk);
    chk("b_idle_done", b_done === 1'b0, b_done, 1'b0);

    // Reset during an in-flight store: the store must be dropped.
    @(negedge clk);
    a_addr = 32'h20; a_wdata = 32'hFFFFFFFF; a_size = 2'b10; a_wr = 1'b1;
    #1;
    chk("rst_busy_c0", a_busy === 1'b1, a_busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", a_busy === 1'b0, a_busy, 1'b0);
    chk("rst_done", a_done === 1'b0, a_done, 1'b0);
    chk("rst_rdata", a_rdata === 32'd0, a_rdata, 32'd0);
    a_wr = 1'b0;
    @(negedge clk);
    chk("rst_done_hold", a_done === 1'b0, a_done, 1'b0);
    rst_n = 1'b1;
    access("ld_w20_after_rst", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h55555555, 1'b0);

    chk("scoreboard_empty", exp_q.size() === 0, exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
